// File: rtl/voltage_stats_pkg.sv
// Shared types and default constants for the voltage window statistics block:
// alarm FSM states, readout select encodings and default window/threshold values.
package voltage_stats_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_NORMAL = 2'd1,
        ST_OVER   = 2'd2,
        ST_UNDER  = 2'd3
    } alarm_state_e;

    typedef enum logic [1:0] {
        SEL_AVG   = 2'd0,
        SEL_MIN   = 2'd1,
        SEL_MAX   = 2'd2,
        SEL_COUNT = 2'd3
    } readout_sel_e;

    localparam int unsigned DEF_WIN_LOG2 = 3;
    localparam logic [7:0]  DEF_OV_SET   = 8'd200;
    localparam logic [7:0]  DEF_OV_CLR   = 8'd190;
    localparam logic [7:0]  DEF_UV_SET   = 8'd40;
    localparam logic [7:0]  DEF_UV_CLR   = 8'd50;

    localparam logic [7:0]  MIN_INIT     = 8'hFF;
    localparam logic [7:0]  MAX_INIT     = 8'h00;
    localparam logic [7:0]  COUNT_MAX    = 8'hFF;

endpackage

// File: rtl/window_ring_buffer.sv
// Circular sample window with a running sum; produces the truncated window average
// (registered and next-state) plus a sticky flag once the window has filled.
module window_ring_buffer
    import voltage_stats_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       accept_i,
    input  logic [7:0] sample_i,
    output logic [7:0] avg_o,
    output logic [7:0] avg_next_o,
    output logic       avg_valid_o
);

    localparam int unsigned DEPTH  = 1 << WIN_LOG2;
    localparam int unsigned SUM_W  = WIN_LOG2 + 8;
    localparam int unsigned FILL_W = WIN_LOG2 + 1;

    logic [7:0]          mem_q [DEPTH];
    logic [WIN_LOG2-1:0] wr_ptr_q;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [FILL_W-1:0]   fill_q;
    logic [7:0]          avg_q, avg_d;

    // The slot about to be overwritten is the oldest sample; it is zero until the first wrap.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        sum_d = sum_q;
        avg_d = avg_q;
        if (accept_i) begin
            sum_d = sum_q + SUM_W'(sample_i) - SUM_W'(mem_q[wr_ptr_q]);
            avg_d = 8'(sum_d >> WIN_LOG2);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the window memory is reset so the running sum starts from true zeros.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            // NOTE: sequential state uses <= so all registers see pre-edge values.
            wr_ptr_q <= '0;
            sum_q    <= '0;
            avg_q    <= '0;
            fill_q   <= '0;
        end else if (accept_i) begin
            mem_q[wr_ptr_q] <= sample_i;
            wr_ptr_q        <= wr_ptr_q + WIN_LOG2'(1);
            sum_q           <= sum_d;
            avg_q           <= avg_d;
            if (!fill_q[WIN_LOG2]) begin
                fill_q <= fill_q + FILL_W'(1);
            end
        end
    end

    assign avg_o       = avg_q;
    assign avg_next_o  = avg_d;
    assign avg_valid_o = fill_q[WIN_LOG2];

endmodule

// File: rtl/voltage_window_stats.sv
// Voltage monitor: windowed average with hysteretic over/under alarms, min/max/count
// statistics, and a registered readout mux.
module voltage_window_stats
    import voltage_stats_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2,
    parameter logic [7:0]  OV_SET   = DEF_OV_SET,
    parameter logic [7:0]  OV_CLR   = DEF_OV_CLR,
    parameter logic [7:0]  UV_SET   = DEF_UV_SET,
    parameter logic [7:0]  UV_CLR   = DEF_UV_CLR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    input  logic       clr_stats,
    input  logic [1:0] sel,
    output logic [7:0] data_out,
    output logic       avg_valid,
    output logic       over_v,
    output logic       under_v
);

    logic         accept;
    logic [7:0]   avg_q, avg_d;
    logic [7:0]   min_q, min_d, max_q, max_d, cnt_q, cnt_d, dout_q, dout_d;
    alarm_state_e state_q, state_d;

    assign accept = ena & sample_valid;

    window_ring_buffer #(
        .WIN_LOG2(WIN_LOG2)
    ) u_ring (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept_i   (accept),
        .sample_i   (sample_in),
        .avg_o      (avg_q),
        .avg_next_o (avg_d),
        .avg_valid_o(avg_valid)
    );

    // A clear coinciding with a sample restarts the statistics from that sample.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        cnt_d = cnt_q;
        if (ena && clr_stats) begin
            min_d = accept ? sample_in : MIN_INIT;
            max_d = accept ? sample_in : MAX_INIT;
            cnt_d = accept ? 8'd1 : 8'd0;
        end else if (accept) begin
            if (sample_in < min_q) min_d = sample_in;
            if (sample_in > max_q) max_d = sample_in;
            if (cnt_q != COUNT_MAX) cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        case (readout_sel_e'(sel))
            SEL_AVG:   dout_d = avg_d;
            SEL_MIN:   dout_d = min_d;
            SEL_MAX:   dout_d = max_d;
            SEL_COUNT: dout_d = cnt_d;
            default:   dout_d = avg_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_q  <= MIN_INIT;
            max_q  <= MAX_INIT;
            cnt_q  <= '0;
            dout_q <= '0;
        end else if (ena) begin
            min_q  <= min_d;
            max_q  <= max_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    // Alarm FSM: state register, next-state logic, output decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL:   if (avg_valid)       state_d = ST_NORMAL;
            ST_NORMAL: if (avg_q >= OV_SET) state_d = ST_OVER;
                       else if (avg_q <= UV_SET) state_d = ST_UNDER;
            ST_OVER:   if (avg_q <= OV_CLR) state_d = ST_NORMAL;
            ST_UNDER:  if (avg_q >= UV_CLR) state_d = ST_NORMAL;
            default:                        state_d = ST_FILL;
        endcase
    end

    always_comb begin
        over_v  = (state_q == ST_OVER);
        under_v = (state_q == ST_UNDER);
    end

    assign data_out = dout_q;

endmodule
